// File: rtl/lc3b_types.sv
// Shared LC-3b datapath types: opcodes, register/word/tag types, the CDB
// broadcast record and the reorder buffer entry layout.
package lc3b_types;

  localparam int data_width = 16;
  localparam int tag_width  = 3;
  localparam int rob_depth  = 1 << tag_width;

  typedef logic [data_width-1:0] lc3b_word;
  typedef logic [tag_width-1:0]  lc3b_rob_addr;
  typedef logic [2:0]            lc3b_reg;

  typedef enum logic [3:0] {
    op_br   = 4'd0,
    op_add  = 4'd1,
    op_ldb  = 4'd2,
    op_stb  = 4'd3,
    op_jsr  = 4'd4,
    op_and  = 4'd5,
    op_ldr  = 4'd6,
    op_str  = 4'd7,
    op_rti  = 4'd8,
    op_not  = 4'd9,
    op_ldi  = 4'd10,
    op_sti  = 4'd11,
    op_jmp  = 4'd12,
    op_shf  = 4'd13,
    op_lea  = 4'd14,
    op_trap = 4'd15
  } lc3b_opcode;

  typedef struct packed {
    logic         valid;
    lc3b_rob_addr tag;
    lc3b_word     data;
  } CDB;

  typedef struct packed {
    logic       busy;
    logic       ready;
    lc3b_opcode opcode;
    lc3b_reg    dest;
    lc3b_word   value;
  } rob_entry_t;

  // Only these opcodes wait on the CDB and write the register file at retirement.
  function automatic logic is_reg_write(input lc3b_opcode op);
    logic result;
    case (op)
      op_add, op_and, op_not, op_shf, op_ldr: result = 1'b1;
      default:                                result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/rob_storage.sv
// Reorder buffer entry array: one allocate port, one CDB update port, a retire
// port that clears busy, two operand read ports and a head read port.
module rob_storage
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         wr_en,
  input  lc3b_rob_addr wr_idx,
  input  rob_entry_t   wr_entry,
  input  CDB           cdb_in,
  input  logic         retire_en,
  input  lc3b_rob_addr retire_idx,
  input  lc3b_rob_addr rd1_idx,
  input  lc3b_rob_addr rd2_idx,
  input  lc3b_rob_addr head_idx,
  output lc3b_word     rd1_value,
  output lc3b_word     rd2_value,
  output logic         rd1_valid,
  output logic         rd2_valid,
  output rob_entry_t   head_entry
);

  rob_entry_t entries_reg [rob_depth];

  logic [rob_depth-1:0] wr_hit;
  logic [rob_depth-1:0] cdb_hit;
  logic [rob_depth-1:0] retire_hit;

  // A broadcast only lands on an entry that is still waiting for its result.
  generate
    for (genvar gi = 0; gi < rob_depth; gi++) begin : g_hit
      assign wr_hit[gi]     = wr_en && (wr_idx == lc3b_rob_addr'(gi));
      assign cdb_hit[gi]    = cdb_in.valid && (cdb_in.tag == lc3b_rob_addr'(gi)) &&
                              entries_reg[gi].busy && !entries_reg[gi].ready;
      assign retire_hit[gi] = retire_en && (retire_idx == lc3b_rob_addr'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < rob_depth; i++) begin
        entries_reg[i] <= '0;
      end
    end else begin
      for (int i = 0; i < rob_depth; i++) begin
        if (clear) begin
          entries_reg[i].busy  <= 1'b0;
          entries_reg[i].ready <= 1'b0;
        end else if (wr_hit[i]) begin
          entries_reg[i] <= wr_entry;
        end else begin
          if (cdb_hit[i]) begin
            entries_reg[i].value <= cdb_in.data;
            entries_reg[i].ready <= 1'b1;
          end
          if (retire_hit[i]) begin
            entries_reg[i].busy <= 1'b0;
          end
        end
      end
    end
  end

  assign rd1_value  = entries_reg[rd1_idx].value;
  assign rd2_value  = entries_reg[rd2_idx].value;
  assign rd1_valid  = entries_reg[rd1_idx].busy && entries_reg[rd1_idx].ready;
  assign rd2_valid  = entries_reg[rd2_idx].busy && entries_reg[rd2_idx].ready;
  assign head_entry = entries_reg[head_idx];

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order allocation at the tail, CDB result capture,
// operand lookup, and in-order retirement from the head to the register file.
module reorder_buffer
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         write_enable,
  input  lc3b_opcode   opcode_in,
  input  lc3b_reg      dest_in,
  input  lc3b_word     value_in,
  output lc3b_rob_addr rob_addr,
  output logic         rob_full,
  input  CDB           CDB_in,
  input  lc3b_rob_addr sr1_read_addr,
  input  lc3b_rob_addr sr2_read_addr,
  output lc3b_word     sr1_value_out,
  output lc3b_word     sr2_value_out,
  output logic         sr1_valid_out,
  output logic         sr2_valid_out,
  input  logic         flush,
  output logic         commit_ld_reg,
  output lc3b_reg      commit_dest,
  output lc3b_word     commit_value,
  output lc3b_rob_addr commit_rob_entry
);

  lc3b_rob_addr      head_reg;
  lc3b_rob_addr      tail_reg;
  logic [tag_width:0] count_reg;

  logic       alloc_en;
  logic       commit_en;
  rob_entry_t new_entry;
  rob_entry_t head_entry;

  assign rob_full  = (count_reg == (tag_width + 1)'(rob_depth));
  assign alloc_en  = write_enable && !rob_full && !flush;
  assign commit_en = head_entry.busy && head_entry.ready && !flush;
  assign rob_addr  = tail_reg;

  // Non-register-writing instructions have nothing to wait for.
  assign new_entry = '{busy:   1'b1,
                       ready:  !is_reg_write(opcode_in),
                       opcode: opcode_in,
                       dest:   dest_in,
                       value:  value_in};

  rob_storage u_storage (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (flush),
    .wr_en      (alloc_en),
    .wr_idx     (tail_reg),
    .wr_entry   (new_entry),
    .cdb_in     (CDB_in),
    .retire_en  (commit_en),
    .retire_idx (head_reg),
    .rd1_idx    (sr1_read_addr),
    .rd2_idx    (sr2_read_addr),
    .head_idx   (head_reg),
    .rd1_value  (sr1_value_out),
    .rd2_value  (sr2_value_out),
    .rd1_valid  (sr1_valid_out),
    .rd2_valid  (sr2_valid_out),
    .head_entry (head_entry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (alloc_en) begin
        tail_reg <= tail_reg + 1'b1;
      end
      if (commit_en) begin
        head_reg <= head_reg + 1'b1;
      end
      case ({alloc_en, commit_en})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_comb begin
    commit_ld_reg    = 1'b0;
    commit_dest      = '0;
    commit_value     = '0;
    commit_rob_entry = '0;
    if (commit_en) begin
      commit_ld_reg    = is_reg_write(head_entry.opcode);
      commit_dest      = head_entry.dest;
      commit_value     = head_entry.value;
      commit_rob_entry = head_reg;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: allocation, CDB capture, in-order commit,
// full/wrap behaviour, flush priority and asynchronous reset.
module tb_reorder_buffer;
  import lc3b_types::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         write_enable;
  lc3b_opcode   opcode_in;
  lc3b_reg      dest_in;
  lc3b_word     value_in;
  lc3b_rob_addr rob_addr;
  logic         rob_full;
  CDB           cdb_in;
  lc3b_rob_addr sr1_read_addr;
  lc3b_rob_addr sr2_read_addr;
  lc3b_word     sr1_value_out;
  lc3b_word     sr2_value_out;
  logic         sr1_valid_out;
  logic         sr2_valid_out;
  logic         flush;
  logic         commit_ld_reg;
  lc3b_reg      commit_dest;
  lc3b_word     commit_value;
  lc3b_rob_addr commit_rob_entry;

  int pass_cnt  = 0;
  int total_cnt = 0;

  reorder_buffer dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .write_enable     (write_enable),
    .opcode_in        (opcode_in),
    .dest_in          (dest_in),
    .value_in         (value_in),
    .rob_addr         (rob_addr),
    .rob_full         (rob_full),
    .CDB_in           (cdb_in),
    .sr1_read_addr    (sr1_read_addr),
    .sr2_read_addr    (sr2_read_addr),
    .sr1_value_out    (sr1_value_out),
    .sr2_value_out    (sr2_value_out),
    .sr1_valid_out    (sr1_valid_out),
    .sr2_valid_out    (sr2_valid_out),
    .flush            (flush),
    .commit_ld_reg    (commit_ld_reg),
    .commit_dest      (commit_dest),
    .commit_value     (commit_value),
    .commit_rob_entry (commit_rob_entry)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
      $display("check %-22s observed 0x%0h expected 0x%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cdb(input logic v, input lc3b_rob_addr t, input lc3b_word d);
    cdb_in.valid = v;
    cdb_in.tag   = t;
    cdb_in.data  = d;
  endtask

  task automatic issue(input logic en, input lc3b_opcode op, input lc3b_reg d, input lc3b_word v);
    write_enable = en;
    opcode_in    = op;
    dest_in      = d;
    value_in     = v;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    sr1_read_addr = '0;
    sr2_read_addr = '0;
    issue(1'b0, op_br, 3'd0, 16'h0000);
    set_cdb(1'b0, 3'd0, 16'h0000);
    #3;
    check("rst_rob_addr", 32'(rob_addr), 32'd0);
    check("rst_rob_full", 32'(rob_full), 32'd0);
    check("rst_sr1_valid", 32'(sr1_valid_out), 32'd0);
    check("rst_sr2_value", 32'(sr2_value_out), 32'd0);
    check("rst_commit_ld", 32'(commit_ld_reg), 32'd0);
    check("rst_commit_entry", 32'(commit_rob_entry), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Single add: issue, CDB, commit.
    issue(1'b1, op_add, 3'd1, 16'h0000);
    #1 check("add_addr_before", 32'(rob_addr), 32'd0);
    tick();
    issue(1'b0, op_add, 3'd1, 16'h0000);
    set_cdb(1'b1, 3'd0, 16'h0005);
    #1;
    check("add_addr_after", 32'(rob_addr), 32'd1);
    check("add_not_ready", 32'(sr1_valid_out), 32'd0);
    check("add_no_commit_yet", 32'(commit_ld_reg), 32'd0);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0000);
    #1;
    check("cdb_sr1_valid", 32'(sr1_valid_out), 32'd1);
    check("cdb_sr1_value", 32'(sr1_value_out), 32'h0005);
    check("add_commit_ld", 32'(commit_ld_reg), 32'd1);
    check("add_commit_dest", 32'(commit_dest), 32'd1);
    check("add_commit_value", 32'(commit_value), 32'h0005);
    check("add_commit_entry", 32'(commit_rob_entry), 32'd0);
    tick();
    check("add_retired", 32'(commit_ld_reg), 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1 check("flush_rob_addr", 32'(rob_addr), 32'd0);

    // Fill all eight slots; the ninth request must be ignored.
    for (int i = 0; i < 8; i++) begin
      issue(1'b1, op_add, lc3b_reg'(7 - i), 16'h0000);
      #1 check("fill_not_full", 32'(rob_full), 32'd0);
      tick();
    end
    check("fill_full", 32'(rob_full), 32'd1);
    check("fill_tail_wrapped", 32'(rob_addr), 32'd0);
    tick();
    issue(1'b0, op_add, 3'd0, 16'h0000);
    sr2_read_addr = 3'd7;
    #1;
    check("ninth_ignored_tail", 32'(rob_addr), 32'd0);
    check("ninth_still_full", 32'(rob_full), 32'd1);
    check("pending_sr2_valid", 32'(sr2_valid_out), 32'd0);

    // Full buffer with a ready head and write_enable held.
    set_cdb(1'b1, 3'd0, 16'h1111);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0000);
    issue(1'b1, op_br, 3'd0, 16'hBEEF);
    #1;
    check("full_commit_stall", 32'(rob_full), 32'd1);
    check("full_commit_ld", 32'(commit_ld_reg), 32'd1);
    check("full_commit_entry", 32'(commit_rob_entry), 32'd0);
    check("full_commit_value", 32'(commit_value), 32'h1111);
    check("full_commit_dest", 32'(commit_dest), 32'd7);
    tick();
    check("slot_freed", 32'(rob_full), 32'd0);
    check("slot_tail_same", 32'(rob_addr), 32'd0);
    check("head1_not_ready", 32'(commit_ld_reg), 32'd0);
    tick();
    issue(1'b0, op_br, 3'd0, 16'h0000);
    sr1_read_addr = 3'd0;
    #1;
    check("wrap_alloc_addr", 32'(rob_addr), 32'd1);
    check("wrap_full_again", 32'(rob_full), 32'd1);
    check("wrap_br_valid", 32'(sr1_valid_out), 32'd1);
    check("wrap_br_value", 32'(sr1_value_out), 32'hBEEF);

    // Out-of-order completion 3, 2, 1 retires in order 1, 2, 3.
    set_cdb(1'b1, 3'd3, 16'h0300);
    #1 check("ooo_wait_a", 32'(commit_ld_reg), 32'd0);
    tick();
    set_cdb(1'b1, 3'd2, 16'h0200);
    #1 check("ooo_wait_b", 32'(commit_ld_reg), 32'd0);
    tick();
    set_cdb(1'b1, 3'd1, 16'h0100);
    #1 check("ooo_wait_c", 32'(commit_ld_reg), 32'd0);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0000);
    #1;
    check("ooo_c1_entry", 32'(commit_rob_entry), 32'd1);
    check("ooo_c1_value", 32'(commit_value), 32'h0100);
    check("ooo_c1_dest", 32'(commit_dest), 32'd6);
    tick();
    check("ooo_not_full", 32'(rob_full), 32'd0);
    check("ooo_c2_entry", 32'(commit_rob_entry), 32'd2);
    check("ooo_c2_value", 32'(commit_value), 32'h0200);
    tick();
    check("ooo_c3_entry", 32'(commit_rob_entry), 32'd3);
    check("ooo_c3_value", 32'(commit_value), 32'h0300);
    tick();
    check("ooo_head4_waits", 32'(commit_ld_reg), 32'd0);

    // Broadcast to an already-ready entry is ignored.
    set_cdb(1'b1, 3'd0, 16'h9999);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0000);
    #1;
    check("stale_cdb_value", 32'(sr1_value_out), 32'hBEEF);
    check("stale_cdb_valid", 32'(sr1_valid_out), 32'd1);

    // Flush wins over a ready head, an allocate and a CDB broadcast.
    set_cdb(1'b1, 3'd4, 16'h4444);
    tick();
    flush = 1'b1;
    issue(1'b1, op_add, 3'd5, 16'h0000);
    set_cdb(1'b1, 3'd5, 16'h5555);
    #1;
    check("flush_no_commit_ld", 32'(commit_ld_reg), 32'd0);
    check("flush_no_commit_val", 32'(commit_value), 32'd0);
    check("flush_no_commit_ent", 32'(commit_rob_entry), 32'd0);
    tick();
    flush = 1'b0;
    issue(1'b0, op_add, 3'd0, 16'h0000);
    set_cdb(1'b0, 3'd0, 16'h0000);
    sr1_read_addr = 3'd5;
    sr2_read_addr = 3'd4;
    #1;
    check("post_flush_addr", 32'(rob_addr), 32'd0);
    check("post_flush_full", 32'(rob_full), 32'd0);
    check("post_flush_sr1", 32'(sr1_valid_out), 32'd0);
    check("post_flush_sr2", 32'(sr2_valid_out), 32'd0);
    check("post_flush_commit", 32'(commit_dest), 32'd0);

    // Branch at the head retires the cycle after allocation.
    issue(1'b1, op_br, 3'd3, 16'h00AB);
    #1 check("br_pre_commit", 32'(commit_dest), 32'd0);
    tick();
    issue(1'b0, op_br, 3'd0, 16'h0000);
    #1;
    check("br_commit_ld", 32'(commit_ld_reg), 32'd0);
    check("br_commit_dest", 32'(commit_dest), 32'd3);
    check("br_commit_value", 32'(commit_value), 32'h00AB);
    check("br_rob_addr", 32'(rob_addr), 32'd1);
    tick();
    check("br_retired", 32'(commit_dest), 32'd0);

    // Asynchronous reset in the middle of a commit.
    issue(1'b1, op_and, 3'd2, 16'h0000);
    tick();
    issue(1'b0, op_and, 3'd0, 16'h0000);
    set_cdb(1'b1, 3'd1, 16'h7777);
    tick();
    set_cdb(1'b0, 3'd0, 16'h0000);
    sr1_read_addr = 3'd1;
    #1;
    check("pre_rst_commit_ld", 32'(commit_ld_reg), 32'd1);
    check("pre_rst_commit_val", 32'(commit_value), 32'h7777);
    check("pre_rst_commit_ent", 32'(commit_rob_entry), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_commit_ld", 32'(commit_ld_reg), 32'd0);
    check("arst_commit_val", 32'(commit_value), 32'd0);
    check("arst_commit_ent", 32'(commit_rob_entry), 32'd0);
    check("arst_rob_addr", 32'(rob_addr), 32'd0);
    check("arst_sr1_valid", 32'(sr1_valid_out), 32'd0);
    check("arst_sr1_value", 32'(sr1_value_out), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
